mac_accum: RTL



---
 rtl/mac_accum_pkg.sv | 40 ++++
 rtl/mac_product_reg.sv | 46 ++++
 rtl/mac_accum.sv | 114 +++++++++++
 3 files changed

// File: rtl/mac_accum_pkg.sv
// Shared widths, log helper and saturation bounds for the signed MAC accumulator.
// Bounds are carried in 64-bit form, so output widths up to 64 bits are supported.
package mac_accum_pkg;

  localparam int FEATURE_W_DEF = 16;
  localparam int WEIGHT_W_DEF  = 16;
  localparam int MAX_LEN_DEF   = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int pw(input int fw, input int ww);
    return fw + ww;
  endfunction

  function automatic int ow(input int fw, input int ww);
    return pw(fw, ww) + 1;
  endfunction

  function automatic int aw(input int fw, input int ww, input int max_len);
    return ow(fw, ww) + clog2(max_len);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(ow(FEATURE_W_DEF, WEIGHT_W_DEF));
  localparam longint SAT_MIN_DEF = sat_min(ow(FEATURE_W_DEF, WEIGHT_W_DEF));

endpackage

// File: rtl/mac_product_reg.sv
// Stage-1 signed multiply with registered valid/last; reusable across MAC lanes.
module mac_product_reg
  import mac_accum_pkg::*;
#(
  parameter int FW = FEATURE_W_DEF,
  parameter int WW = WEIGHT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  input  logic                      i_last,
  input  logic [FW-1:0]             i_a,
  input  logic [WW-1:0]             i_b,
  output logic signed [FW+WW-1:0]   o_prod,
  output logic                      o_valid,
  output logic                      o_last
);

  localparam int PW = pw(FW, WW);

  logic signed [PW-1:0] w_a, w_b, w_prod;
  logic signed [PW-1:0] r_prod;
  logic                 r_valid, r_last;

  // Operands widened to the product width so the low PW bits are the exact product.
  assign w_a    = {{WW{i_a[FW-1]}}, i_a};
  assign w_b    = {{FW{i_b[WW-1]}}, i_b};
  assign w_prod = w_a * w_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_last  <= i_valid & i_last;
      if (i_valid) r_prod <= w_prod;
    end
  end

  assign o_prod  = r_prod;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/mac_accum.sv
// Pipelined signed multiply-accumulate over last-framed vectors, with a saturated
// full-precision result pulsed toward the down-scaler.
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int featureWidth = FEATURE_W_DEF,
  parameter int weightWidth  = WEIGHT_W_DEF,
  parameter int MAX_LEN      = MAX_LEN_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  input  logic [featureWidth-1:0]               feature,
  input  logic [weightWidth-1:0]                weight,
  output logic                                  out_valid,
  output logic [featureWidth+weightWidth:0]     out_sum,
  output logic [clog2(MAX_LEN):0]               out_count,
  output logic                                  out_sat,
  output logic                                  out_len_err
);

  localparam int PW = pw(featureWidth, weightWidth);
  localparam int OW = ow(featureWidth, weightWidth);
  localparam int AW = aw(featureWidth, weightWidth, MAX_LEN);
  localparam int CW = clog2(MAX_LEN) + 1;
  localparam logic [OW-1:0] SAT_MAX = OW'(sat_max(OW));
  localparam logic [OW-1:0] SAT_MIN = OW'(sat_min(OW));

  logic signed [PW-1:0] w_p1;
  logic                 w_v1, w_l1;

  mac_product_reg #(.FW(featureWidth), .WW(weightWidth)) u_prod (
    .clk     (clk),
    .reset   (reset),
    .i_valid (in_valid),
    .i_last  (in_last),
    .i_a     (feature),
    .i_b     (weight),
    .o_prod  (w_p1),
    .o_valid (w_v1),
    .o_last  (w_l1)
  );

  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_first, r_close, r_len_err;
  logic [AW-1:0]      w_acc_next;
  logic [CW-1:0]      w_cnt_next;
  logic               w_at_max, w_close;

  assign w_acc_next = (r_first ? '0 : r_acc) + {{(AW-PW){w_p1[PW-1]}}, w_p1};
  assign w_cnt_next = r_first ? CW'(1) : r_cnt + CW'(1);
  assign w_at_max   = (w_cnt_next == CW'(MAX_LEN));
  assign w_close    = w_v1 & (w_l1 | w_at_max);

  // r_acc/r_cnt keep the closed vector's totals until the next beat, which the
  // output stage reads one cycle later; r_first makes that next beat start fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
      r_close   <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_close <= w_close;
      if (w_v1) begin
        r_acc     <= w_acc_next;
        r_cnt     <= w_cnt_next;
        r_first   <= w_l1 | w_at_max;
        r_len_err <= w_at_max & ~w_l1;
      end
    end
  end

  logic [AW-OW:0] w_hi;
  logic           w_ovf;
  logic [OW-1:0]  w_sat_sum;

  // Fits in OW bits only when every bit above the OW sign position matches it.
  assign w_hi      = r_acc[AW-1:OW-1];
  assign w_ovf     = ~((&w_hi) | ~(|w_hi));
  assign w_sat_sum = w_ovf ? (r_acc[AW-1] ? SAT_MIN : SAT_MAX) : r_acc[OW-1:0];

  logic          r_out_valid, r_out_sat, r_out_len_err;
  logic [OW-1:0] r_out_sum;
  logic [CW-1:0] r_out_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_sum     <= '0;
      r_out_count   <= '0;
      r_out_sat     <= 1'b0;
      r_out_len_err <= 1'b0;
    end else begin
      r_out_valid <= r_close;
      if (r_close) begin
        r_out_sum     <= w_sat_sum;
        r_out_count   <= r_cnt;
        r_out_sat     <= w_ovf;
        r_out_len_err <= r_len_err;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_sum     = r_out_sum;
  assign out_count   = r_out_count;
  assign out_sat     = r_out_sat;
  assign out_len_err = r_out_len_err;

endmodule
